// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer: fetches sequential words into a DEPTH-entry {addr, inst} queue
// and presents the head to decode. One bus request in flight; a jump flushes the queue and drops the in-flight reply.
module if_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];

  logic          not_full;
  logic          not_empty;
  logic          gnt_fire;
  logic          rsp;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  assign not_full  = (count_q < FULL_CNT);
  assign not_empty = (count_q != '0);

  // The request is gated by reset so nothing is presented to the bus while rst is low.
  assign ibus_req_o  = rst & ~outstanding_q & not_full & ~jump_flag_i;
  assign ibus_addr_o = fetch_pc_q;

  assign gnt_fire = ibus_req_o & ibus_gnt_i;
  assign rsp      = ibus_rvalid_i & outstanding_q;
  assign push     = rsp & ~discard_q & ~jump_flag_i;
  assign pop      = not_empty & ~hold_flag_i & ~jump_flag_i;

  assign head         = mem_q[rd_ptr_q];
  assign inst_valid_o = rst & not_empty;
  assign inst_o       = inst_valid_o ? head[31:0]  : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? head[63:32] : 32'h0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pend_addr_d   = pend_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;

    if (jump_flag_i) begin
      fetch_pc_d = jump_addr_i;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      // A reply landing with the jump is the one that would have been discarded anyway.
      if (rsp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end else if (outstanding_q) begin
        discard_d = 1'b1;
      end
    end else begin
      if (gnt_fire) begin
        outstanding_d = 1'b1;
        pend_addr_d   = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (rsp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (push) begin
        mem_d[wr_ptr_q] = {pend_addr_q, ibus_rdata_i};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      pend_addr_q   <= 32'h0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pend_addr_q   <= pend_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'h0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Randomized bench for if_prefetch_buf: a bus slave with variable latency plus a queue-based reference model.
module tb_if_prefetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0001;
  localparam logic [31:0] RD_XOR   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  if_prefetch_buf #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: program-order queue of {addr, inst}, next fetch pc, one in-flight slot.
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_out;
  bit          m_disc;
  logic [63:0] m_q[$];

  // Bus slave: single outstanding, reply 1..max_lat cycles after grant.
  bit          sl_busy;
  int          sl_cnt;
  logic [31:0] sl_addr;

  int p_gnt, p_hold, p_jump, p_stray, max_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 32'hFFFF_FFF8;
    if (sel == 1) return $urandom;
    return $urandom_range(0, 255) << 2;
  endfunction

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_pend = 32'h0;
    m_out  = 1'b0;
    m_disc = 1'b0;
    m_q.delete();
  endtask

  task automatic check_outputs(input bit m_req);
    logic [31:0] e_inst, e_addr;
    e_inst = NOP_INST;
    e_addr = 32'h0;
    if (m_q.size() != 0) begin
      e_inst = m_q[0][31:0];
      e_addr = m_q[0][63:32];
    end
    check("req", {31'h0, ibus_req_o}, {31'h0, m_req});
    check("ibus_addr", ibus_addr_o, m_pc);
    check("valid", {31'h0, inst_valid_o}, {31'h0, (m_q.size() != 0)});
    check("inst", inst_o, e_inst);
    check("inst_addr", inst_addr_o, e_addr);
  endtask

  task automatic step();
    bit m_req, rsp, slave_reply;
    @(negedge clk);
    jump_flag_i = ($urandom_range(0, 99) < p_jump);
    jump_addr_i = pick_target();
    hold_flag_i = ($urandom_range(0, 99) < p_hold);
    ibus_gnt_i  = !sl_busy && ($urandom_range(0, 99) < p_gnt);
    slave_reply = sl_busy && (sl_cnt == 1);
    if (slave_reply) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = sl_addr ^ RD_XOR;
    end else begin
      ibus_rvalid_i = !sl_busy && !m_out && ($urandom_range(0, 99) < p_stray);
      ibus_rdata_i  = $urandom;
    end
    #1;
    m_req = !m_out && (m_q.size() < DEPTH) && !jump_flag_i;
    check_outputs(m_req);

    if (slave_reply) sl_busy = 1'b0;
    else if (sl_busy) sl_cnt--;
    if (ibus_req_o && ibus_gnt_i) begin
      sl_busy = 1'b1;
      sl_cnt  = $urandom_range(1, max_lat);
      sl_addr = ibus_addr_o;
    end

    rsp = ibus_rvalid_i && m_out;
    if (jump_flag_i) begin
      m_q.delete();
      m_pc = jump_addr_i;
      if (rsp) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end else if (m_out) begin
        m_disc = 1'b1;
      end
    end else begin
      if (m_q.size() != 0 && !hold_flag_i) void'(m_q.pop_front());
      if (rsp) begin
        m_out = 1'b0;
        if (m_disc) m_disc = 1'b0;
        else m_q.push_back({m_pend, ibus_rdata_i});
      end
      if (m_req && ibus_gnt_i) begin
        m_out  = 1'b1;
        m_pend = m_pc;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic set_knobs(input int g, input int h, input int j, input int s, input int l);
    p_gnt = g; p_hold = h; p_jump = j; p_stray = s; max_lat = l;
  endtask

  task automatic reset_checks();
    check("rst_req", {31'h0, ibus_req_o}, 32'h0);
    check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    check("rst_inst", inst_o, NOP_INST);
    check("rst_inst_addr", inst_addr_o, 32'h0);
  endtask

  task automatic idle_inputs();
    jump_flag_i   = 1'b0;
    jump_addr_i   = 32'h0;
    hold_flag_i   = 1'b0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'h0;
  endtask

  task automatic mid_reset();
    int n;
    n = 0;
    while (!sl_busy && n < 100) begin
      step();
      n++;
    end
    check("rst_wait_busy", {31'h0, sl_busy}, 32'h1);
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b0;
    #1 reset_checks();
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1'b1;
    // The slave still owes a reply from before reset; it must be ignored.
    if (sl_busy) sl_cnt = 2;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    sl_busy = 1'b0;
    sl_cnt  = 0;
    sl_addr = 32'h0;
    model_reset();
    set_knobs(100, 0, 0, 0, 1);
    #1 reset_checks();
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1'b1;

    // Back-to-back streaming from RESET_PC.
    repeat (20) step();
    // Stall decode until the queue is full, then drain.
    set_knobs(100, 100, 0, 0, 1);
    repeat (10) step();
    set_knobs(100, 0, 0, 0, 1);
    repeat (15) step();
    // Jumps against slow replies.
    set_knobs(100, 10, 15, 0, 3);
    repeat (150) step();
    // Grant withheld: request stable, queue drains to NOP.
    set_knobs(0, 0, 0, 0, 1);
    repeat (8) step();
    // Reset while a reply is still owed.
    set_knobs(100, 0, 0, 0, 3);
    mid_reset();
    repeat (20) step();
    // Mixed random traffic.
    set_knobs(70, 30, 8, 10, 3);
    repeat (2000) step();
    set_knobs(50, 50, 25, 10, 3);
    repeat (1000) step();
    set_knobs(100, 0, 0, 0, 3);
    mid_reset();
    repeat (50) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch_buf.md
Name: if_prefetch_buf

Overview:
Instruction prefetch buffer between the instruction bus and the decode stage. Fetches sequential words from ifetch_pc and queues up to DEPTH {addr, inst} pairs. Presents the queue head to decode as inst_o/inst_addr_o, so decode sees a NOP bubble rather than stale data when fetch stalls. Flushes on execute-stage jumps, and honours pipeline hold by not popping.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0001, instruction word presented when the queue is empty

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
jump_flag_i  in  1  jump/flush request from ex
jump_addr_i  in  32  new fetch address when jump_flag_i=1
hold_flag_i  in  1  decode/ex stall; 1 = head must not be consumed
ibus_req_o  out  1  fetch request valid
ibus_addr_o  out  32  fetch address (= fetch_pc)
ibus_gnt_i  in  1  request accepted this cycle
ibus_rvalid_i  in  1  read data valid; 1+ cycles after grant
ibus_rdata_i  in  32  instruction word
inst_o  out  32  head instruction to decode, or NOP_INST when empty
inst_addr_o  out  32  head address, or 0 when empty
inst_valid_o  out  1  queue non-empty

Behaviour:
- State:
  - fetch_pc[31:0]
  - pend_addr[31:0]: address of the in-flight request
  - outstanding (1 bit)
  - discard (1 bit)
  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap modulo DEPTH
  - count: 0..DEPTH
  - storage: DEPTH x 64 bits
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; pointers, count, outstanding, discard = 0.
  - Outputs while in reset: ibus_req_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
- Request:
  - ibus_req_o = rst & ~outstanding & (count<DEPTH) & ~jump_flag_i.
  - ibus_addr_o = fetch_pc.
  - At most one request outstanding.
- Grant (ibus_req_o & ibus_gnt_i):
  - outstanding<=1, pend_addr<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, no carry out).
- Response:
  - When ibus_rvalid_i & outstanding: outstanding<=0.
  - If discard=0, push {pend_addr, ibus_rdata_i} at wr_ptr. If discard=1, drop the word and clear discard.
  - ibus_rvalid_i with outstanding=0 is ignored (covers a stale reply after reset).
- Output:
  - Combinational from the head entry.
  - A pushed word is visible on inst_o the cycle after rvalid (1-cycle latency).
- Pop: count>0 & ~hold_flag_i & ~jump_flag_i; advances rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count=DEPTH): no request issued. A response in flight can never overflow, because a request requires count<DEPTH and no pop can reduce headroom.
- Jump (jump_flag_i=1) has highest priority:
  - Next edge: count<=0, rd_ptr<=wr_ptr, fetch_pc<=jump_addr_i; no pop.
  - Response arriving same cycle as the jump: not pushed, clears outstanding.
  - Outstanding request with no response that cycle: discard<=1.
  - Grant cannot occur that cycle because req is gated.
  - inst_o shows NOP_INST from the next cycle.
- Back-to-back jumps: each one reloads fetch_pc. discard stays 1 until exactly one response is dropped.
- Hold with empty queue: no effect. Fetching continues until the queue is full.
- jump_addr_i misalignment is not checked; fetch_pc bits[1:0] are carried as-is.

Test Plan:
- Reset release, gnt=1 every cycle, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000 -> ibus_addr_o=0,4,8; inst_addr_o 0,4,8... with matching inst_o; inst_valid_o first high 2 cycles after reset release.
- hold_flag_i=1 for 10 cycles during streaming -> count saturates at 4, ibus_req_o=0 while full; after release, 4 entries drain in order 0x0..0xC with no loss or duplication.
- Request at 0x10 granted, rvalid delayed 3 cycles, jump_flag_i=1 with jump_addr_i=0x100 in the cycle after grant -> rdata for 0x10 dropped; first queued entry has inst_addr_o=0x100; inst_o=NOP_INST in between.
- jump_flag_i asserted in the same cycle as rvalid -> word dropped, outstanding cleared, next ibus_addr_o=jump target, discard stays 0.
- rst pulled low mid-transfer with a request outstanding, then released; a late rvalid arrives -> rvalid ignored, queue empty, first fetch at RESET_PC.
- ibus_gnt_i withheld for 5 cycles -> ibus_req_o and ibus_addr_o stable; inst_o=NOP_INST, inst_valid_o=0 after the queue drains.
